// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned AW_DEF   = 5;

    localparam int unsigned REQ_ALU  = 0;
    localparam int unsigned REQ_LSU  = 1;
    localparam int unsigned NUM_REQ  = 2;

    typedef enum logic {
        ReqAlu = 1'b0,
        ReqLsu = 1'b1
    } req_e;

endpackage

// File: rtl/regfile_wb_arbiter_hold_buf.sv
// wb_hold_buf: single-entry writeback holding buffer (valid, destination register, data).
module wb_hold_buf #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [AW-1:0]   rd_i,
    input  logic [XLEN-1:0] data_i,
    output logic            valid_o,
    output logic [AW-1:0]   rd_o,
    output logic [XLEN-1:0] data_o
);

    logic            valid_d, valid_q;
    logic [AW-1:0]   rd_d, rd_q;
    logic [XLEN-1:0] data_d, data_q;

    // A push on the same edge as a pop refills the entry with the new request.
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        data_d  = data_q;
        if (push_i) begin
            valid_d = 1'b1;
            rd_d    = rd_i;
            data_d  = data_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign rd_o    = rd_q;
    assign data_o  = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester (ALU, LSU) register-file writeback arbiter with oldest-first grant.
// Optional macro WB_FWD_EN adds two forwarding lookup ports into the holding buffers.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned AW   = AW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_vld,
    output logic            alu_rdy,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_vld,
    output logic            lsu_rdy,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            we,
    output logic [AW-1:0]   wa,
    output logic [XLEN-1:0] wd,
    output logic            idle
`ifdef WB_FWD_EN
    ,
    input  logic [AW-1:0]   fa1,
    input  logic [AW-1:0]   fa2,
    output logic            fhit1,
    output logic            fhit2,
    output logic [XLEN-1:0] fdata1,
    output logic [XLEN-1:0] fdata2
`endif
);

    logic [NUM_REQ-1:0] buf_vld;
    logic [AW-1:0]      buf_rd   [NUM_REQ];
    logic [XLEN-1:0]    buf_data [NUM_REQ];
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] vld_nxt;

    // older_q names the older entry; only meaningful while both buffers are valid.
    req_e older_d, older_q;
    req_e rr_d, rr_q;

    assign push[REQ_ALU] = alu_vld & alu_rdy;
    assign push[REQ_LSU] = lsu_vld & lsu_rdy;

    wb_hold_buf #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_alu_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push[REQ_ALU]),
        .pop_i   (gnt[REQ_ALU]),
        .rd_i    (alu_rd),
        .data_i  (alu_data),
        .valid_o (buf_vld[REQ_ALU]),
        .rd_o    (buf_rd[REQ_ALU]),
        .data_o  (buf_data[REQ_ALU])
    );

    wb_hold_buf #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_lsu_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push[REQ_LSU]),
        .pop_i   (gnt[REQ_LSU]),
        .rd_i    (lsu_rd),
        .data_i  (lsu_data),
        .valid_o (buf_vld[REQ_LSU]),
        .rd_o    (buf_rd[REQ_LSU]),
        .data_o  (buf_data[REQ_LSU])
    );

    always_comb begin
        gnt = buf_vld;
        if (buf_vld[REQ_ALU] && buf_vld[REQ_LSU]) begin
            gnt = '0;
            if (older_q == ReqAlu) begin
                gnt[REQ_ALU] = 1'b1;
            end else begin
                gnt[REQ_LSU] = 1'b1;
            end
        end
    end

    assign alu_rdy = ~buf_vld[REQ_ALU] | gnt[REQ_ALU];
    assign lsu_rdy = ~buf_vld[REQ_LSU] | gnt[REQ_LSU];
    assign idle    = ~|buf_vld;

    // Writes to x0 are drained silently.
    always_comb begin
        we = 1'b0;
        wa = '0;
        wd = '0;
        if (gnt[REQ_ALU] && (buf_rd[REQ_ALU] != '0)) begin
            we = 1'b1;
            wa = buf_rd[REQ_ALU];
            wd = buf_data[REQ_ALU];
        end else if (gnt[REQ_LSU] && (buf_rd[REQ_LSU] != '0)) begin
            we = 1'b1;
            wa = buf_rd[REQ_LSU];
            wd = buf_data[REQ_LSU];
        end
    end

    assign vld_nxt = push | (buf_vld & ~gnt);

    always_comb begin
        older_d = older_q;
        rr_d    = rr_q;
        if (push[REQ_ALU] && push[REQ_LSU]) begin
            older_d = rr_q;
            rr_d    = (rr_q == ReqAlu) ? ReqLsu : ReqAlu;
        end else if (push[REQ_ALU] && vld_nxt[REQ_LSU]) begin
            older_d = ReqLsu;
        end else if (push[REQ_LSU] && vld_nxt[REQ_ALU]) begin
            older_d = ReqAlu;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            older_q <= ReqAlu;
            rr_q    <= ReqAlu;
        end else begin
            older_q <= older_d;
            rr_q    <= rr_d;
        end
    end

`ifdef WB_FWD_EN
    logic [AW-1:0]   fa      [2];
    logic [1:0]      fhit;
    logic [XLEN-1:0] fdata   [2];
    logic [1:0]      fm_alu;
    logic [1:0]      fm_lsu;

    assign fa[0] = fa1;
    assign fa[1] = fa2;

    // When both entries match, the younger (not older_q) one holds the newest value.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            fm_alu[n] = buf_vld[REQ_ALU] && (buf_rd[REQ_ALU] == fa[n]) && (fa[n] != '0);
            fm_lsu[n] = buf_vld[REQ_LSU] && (buf_rd[REQ_LSU] == fa[n]) && (fa[n] != '0);
            fhit[n]   = fm_alu[n] | fm_lsu[n];
            fdata[n]  = '0;
            if (fm_alu[n] && fm_lsu[n]) begin
                fdata[n] = (older_q == ReqAlu) ? buf_data[REQ_LSU] : buf_data[REQ_ALU];
            end else if (fm_alu[n]) begin
                fdata[n] = buf_data[REQ_ALU];
            end else if (fm_lsu[n]) begin
                fdata[n] = buf_data[REQ_LSU];
            end
        end
    end

    assign fhit1  = fhit[0];
    assign fhit2  = fhit[1];
    assign fdata1 = fdata[0];
    assign fdata2 = fdata[1];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random traffic vs a model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_vld, lsu_vld;
    logic        alu_rdy, lsu_rdy;
    logic [4:0]  alu_rd, lsu_rd;
    logic [31:0] alu_data, lsu_data;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        idle;
`ifdef WB_FWD_EN
    logic [4:0]  fa1, fa2;
    logic        fhit1, fhit2;
    logic [31:0] fdata1, fdata2;
`endif

    regfile_wb_arbiter #(
        .XLEN (32),
        .AW   (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .alu_vld  (alu_vld),
        .alu_rdy  (alu_rdy),
        .alu_rd   (alu_rd),
        .alu_data (alu_data),
        .lsu_vld  (lsu_vld),
        .lsu_rdy  (lsu_rdy),
        .lsu_rd   (lsu_rd),
        .lsu_data (lsu_data),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .idle     (idle)
`ifdef WB_FWD_EN
        ,
        .fa1      (fa1),
        .fa2      (fa2),
        .fhit1    (fhit1),
        .fhit2    (fhit2),
        .fdata1   (fdata1),
        .fdata2   (fdata2)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: each buffered entry carries an acceptance sequence number;
    // the smallest number among valid entries is the one written next.
    bit          mv    [2];
    logic [4:0]  mrd   [2];
    logic [31:0] mdata [2];
    int unsigned mseq  [2];
    int unsigned seq_ctr = 0;
    int          mrr = 0;
    int          m_g;
    bit          m_rdy [2];
    logic [31:0] mreg  [32];
    logic [31:0] oreg  [32];
    int          owr   [32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mv[0] = 1'b0;
        mv[1] = 1'b0;
        mrr   = 0;
    endtask

`ifdef WB_FWD_EN
    task automatic fwd_exp(input logic [4:0] fa, output logic hit, output logic [31:0] data);
        int best;
        best = -1;
        for (int i = 0; i < 2; i++) begin
            if (mv[i] && mrd[i] == fa && fa != 5'd0) begin
                if (best < 0 || mseq[i] > mseq[best]) best = i;
            end
        end
        hit  = (best >= 0);
        data = (best >= 0) ? mdata[best] : 32'd0;
    endtask
`endif

    task automatic model_check();
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        m_g = -1;
        if (mv[0] && mv[1]) m_g = (mseq[0] < mseq[1]) ? 0 : 1;
        else if (mv[0])     m_g = 0;
        else if (mv[1])     m_g = 1;
        e_we = (m_g >= 0) && (mrd[m_g] != 5'd0);
        e_wa = e_we ? mrd[m_g] : 5'd0;
        e_wd = e_we ? mdata[m_g] : 32'd0;
        m_rdy[0] = !mv[0] || (m_g == 0);
        m_rdy[1] = !mv[1] || (m_g == 1);
        chk("we", {63'd0, we}, {63'd0, e_we});
        chk("wa", {59'd0, wa}, {59'd0, e_wa});
        chk("wd", {32'd0, wd}, {32'd0, e_wd});
        chk("alu_rdy", {63'd0, alu_rdy}, {63'd0, m_rdy[0]});
        chk("lsu_rdy", {63'd0, lsu_rdy}, {63'd0, m_rdy[1]});
        chk("idle", {63'd0, idle}, {63'd0, !(mv[0] || mv[1])});
`ifdef WB_FWD_EN
        begin
            logic        h;
            logic [31:0] d;
            fwd_exp(fa1, h, d);
            chk("fhit1", {63'd0, fhit1}, {63'd0, h});
            chk("fdata1", {32'd0, fdata1}, {32'd0, d});
            fwd_exp(fa2, h, d);
            chk("fhit2", {63'd0, fhit2}, {63'd0, h});
            chk("fdata2", {32'd0, fdata2}, {32'd0, d});
        end
`endif
    endtask

    // One clock: check at negedge, then advance the model at the posedge.
    task automatic cycle();
        bit          in_vld  [2];
        logic [4:0]  in_rd   [2];
        logic [31:0] in_data [2];
        bit          push    [2];
        @(negedge clk);
        model_check();
        if (we === 1'b1) begin
            oreg[wa] = wd;
            owr[wa]++;
        end
        in_vld[0] = alu_vld;  in_rd[0] = alu_rd;  in_data[0] = alu_data;
        in_vld[1] = lsu_vld;  in_rd[1] = lsu_rd;  in_data[1] = lsu_data;
        @(posedge clk);
        push[0] = in_vld[0] && m_rdy[0];
        push[1] = in_vld[1] && m_rdy[1];
        if (m_g >= 0) begin
            if (mrd[m_g] != 5'd0) mreg[mrd[m_g]] = mdata[m_g];
            mv[m_g] = 1'b0;
        end
        if (push[0] && push[1]) begin
            mseq[mrr]     = seq_ctr;
            mseq[1 - mrr] = seq_ctr + 1;
            seq_ctr += 2;
            mrr = 1 - mrr;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    mseq[i] = seq_ctr;
                    seq_ctr++;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mv[i]    = 1'b1;
                mrd[i]   = in_rd[i];
                mdata[i] = in_data[i];
            end
        end
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] r, input logic [31:0] d);
        alu_vld = v; alu_rd = r; alu_data = d;
    endtask

    task automatic drive_lsu(input logic v, input logic [4:0] r, input logic [31:0] d);
        lsu_vld = v; lsu_rd = r; lsu_data = d;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mreg[i] = 32'd0;
            oreg[i] = 32'd0;
            owr[i]  = 0;
        end
        model_reset();
        rst = 1'b1;
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_lsu(1'b0, 5'd0, 32'd0);
`ifdef WB_FWD_EN
        fa1 = 5'd0;
        fa2 = 5'd0;
`endif
        #2;
        chk("rst_we", {63'd0, we}, 64'd0);
        chk("rst_wa", {59'd0, wa}, 64'd0);
        chk("rst_wd", {32'd0, wd}, 64'd0);
        chk("rst_idle", {63'd0, idle}, 64'd1);
        chk("rst_alu_rdy", {63'd0, alu_rdy}, 64'd1);
        chk("rst_lsu_rdy", {63'd0, lsu_rdy}, 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset mid-stream discards a pending x5 write.
        drive_alu(1'b1, 5'd5, 32'h5555_5555);
        cycle();
        drive_alu(1'b0, 5'd0, 32'd0);
        chk("pre_rst_we", {63'd0, we}, 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_we", {63'd0, we}, 64'd0);
        chk("midrst_idle", {63'd0, idle}, 64'd1);
        chk("midrst_wa", {59'd0, wa}, 64'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        cycle();
        chk("x5_never_written", owr[5], 64'd0);

        // Single write.
        drive_alu(1'b1, 5'd3, 32'hDEAD_BEEF);
        cycle();
        drive_alu(1'b0, 5'd0, 32'd0);
        chk("single_we", {63'd0, we}, 64'd1);
        chk("single_wa", {59'd0, wa}, 64'd3);
        chk("single_wd", {32'd0, wd}, 64'hDEAD_BEEF);
        cycle();
        chk("single_idle", {63'd0, idle}, 64'd1);

        // Same-edge capture: pointer favours ALU first, then LSU on the next tie.
        drive_alu(1'b1, 5'd7, 32'h11);
        drive_lsu(1'b1, 5'd7, 32'h22);
        cycle();
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_lsu(1'b0, 5'd0, 32'd0);
        chk("tie1_first", {32'd0, wd}, 64'h11);
        cycle();
        chk("tie1_second", {32'd0, wd}, 64'h22);
        cycle();
        drive_alu(1'b1, 5'd8, 32'h33);
        drive_lsu(1'b1, 5'd8, 32'h44);
        cycle();
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_lsu(1'b0, 5'd0, 32'd0);
        chk("tie2_first", {32'd0, wd}, 64'h44);
        cycle();
        chk("tie2_second", {32'd0, wd}, 64'h33);
        cycle();

        // Third tie goes to ALU again; the LSU entry stays blocked for a cycle.
        drive_alu(1'b1, 5'd10, 32'h55);
        drive_lsu(1'b1, 5'd9, 32'hAB);
        cycle();
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_lsu(1'b0, 5'd0, 32'd0);
        chk("tie3_wa", {59'd0, wa}, 64'd10);
        chk("tie3_lsu_rdy", {63'd0, lsu_rdy}, 64'd0);
`ifdef WB_FWD_EN
        fa1 = 5'd9;
        #1;
        chk("fwd_hit9", {63'd0, fhit1}, 64'd1);
        chk("fwd_data9", {32'd0, fdata1}, 64'hAB);
        fa1 = 5'd0;
        #1;
        chk("fwd_hit0", {63'd0, fhit1}, 64'd0);
`endif
        cycle();
        cycle();

        // x0 write drains silently.
        drive_lsu(1'b1, 5'd0, 32'hFFFF_FFFF);
        cycle();
        drive_lsu(1'b0, 5'd0, 32'd0);
        chk("x0_we", {63'd0, we}, 64'd0);
        chk("x0_wd", {32'd0, wd}, 64'd0);
        chk("x0_lsu_rdy", {63'd0, lsu_rdy}, 64'd1);
        cycle();
        chk("x0_idle", {63'd0, idle}, 64'd1);

        // Back-to-back ALU stream.
        for (int i = 1; i <= 8; i++) begin
            drive_alu(1'b1, 5'(i), 32'h100 + 32'(i));
            cycle();
            chk("b2b_we", {63'd0, we}, 64'd1);
            chk("b2b_wa", {59'd0, wa}, 64'(i));
            chk("b2b_alu_rdy", {63'd0, alu_rdy}, 64'd1);
        end
        drive_alu(1'b0, 5'd0, 32'd0);
        cycle();
        chk("b2b_idle", {63'd0, idle}, 64'd1);

        // Random traffic, narrow register range to provoke same-register races.
        for (int c = 0; c < 400; c++) begin
            drive_alu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            drive_lsu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
`ifdef WB_FWD_EN
            fa1 = 5'($urandom_range(0, 7));
            fa2 = 5'($urandom_range(0, 7));
`endif
            cycle();
        end
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_lsu(1'b0, 5'd0, 32'd0);
        for (int c = 0; c < 3; c++) cycle();
        for (int r = 1; r < 11; r++) begin
            chk($sformatf("regfile_x%0d", r), {32'd0, oreg[r]}, {32'd0, mreg[r]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
